// File: rtl/cv32e40p_pkg.sv
// Core-wide constants: ALU operator width and operator encodings.
// Only the ALU subset needed by the EX-stage fault-tolerant logic.
package cv32e40p_pkg;

  localparam int ALU_OP_WIDTH = 7;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD   = 7'b0011000,
    ALU_SUB   = 7'b0011001,
    ALU_ADDU  = 7'b0011010,
    ALU_SUBU  = 7'b0011011,
    ALU_ADDR  = 7'b0011100,
    ALU_SUBR  = 7'b0011101,
    ALU_ADDUR = 7'b0011110,
    ALU_SUBUR = 7'b0011111,
    ALU_XOR   = 7'b0101111,
    ALU_OR    = 7'b0101110,
    ALU_AND   = 7'b0010101,
    ALU_SRA   = 7'b0100100,
    ALU_SRL   = 7'b0100101,
    ALU_ROR   = 7'b0100110,
    ALU_SLL   = 7'b0100111,
    ALU_BEXT  = 7'b0101000,
    ALU_BEXTU = 7'b0101001,
    ALU_BINS  = 7'b0101010,
    ALU_BCLR  = 7'b0101011,
    ALU_BSET  = 7'b0101100,
    ALU_BREV  = 7'b1001001,
    ALU_FF1   = 7'b0110110,
    ALU_FL1   = 7'b0110111,
    ALU_CNT   = 7'b0110100,
    ALU_CLB   = 7'b0110101,
    ALU_EXTS  = 7'b0111110,
    ALU_EXT   = 7'b0111111,
    ALU_LTS   = 7'b0000000,
    ALU_LTU   = 7'b0000001,
    ALU_LES   = 7'b0000100,
    ALU_LEU   = 7'b0000101,
    ALU_GTS   = 7'b0001000,
    ALU_GTU   = 7'b0001001,
    ALU_GES   = 7'b0001010,
    ALU_GEU   = 7'b0001011,
    ALU_EQ    = 7'b0001100,
    ALU_NE    = 7'b0001101,
    ALU_SLTS  = 7'b0000010,
    ALU_SLTU  = 7'b0000011,
    ALU_SLETS = 7'b0000110,
    ALU_SLETU = 7'b0000111,
    ALU_ABS   = 7'b0010100,
    ALU_CLIP  = 7'b0010110,
    ALU_CLIPU = 7'b0010111,
    ALU_INS   = 7'b0101101,
    ALU_MIN   = 7'b0010000,
    ALU_MINU  = 7'b0010010,
    ALU_MAX   = 7'b0010001,
    ALU_MAXU  = 7'b0010011,
    ALU_DIVU  = 7'b0110000,
    ALU_DIV   = 7'b0110001,
    ALU_REMU  = 7'b0110010,
    ALU_REM   = 7'b0110011,
    ALU_SHUF  = 7'b0111010,
    ALU_SHUF2 = 7'b0111011,
    ALU_PCKLO = 7'b0111000,
    ALU_PCKHI = 7'b0111001
  } alu_opcode_e;

endpackage

// File: rtl/cv32e40p_alu_sel_ft_if.sv
// Bundle between the EX stage and the fault-aware ALU selector.
// master = EX stage side, slave = selector side.
interface cv32e40p_alu_sel_ft_if;
  import cv32e40p_pkg::*;

  logic                    alu_enable_i;
  logic [ALU_OP_WIDTH-1:0] alu_operator_i;
  logic                    ex_ready_i;
  logic [3:0][8:0]         permanent_faulty_alu_i;
  logic [3:0]              alu_sel_o;
  logic [1:0]              vote_mode_o;
  logic [8:0]              degraded_o;
  logic [3:0]              clock_en_o;
  logic                    fault_event_o;
  logic                    fatal_err_o;

  modport master (
    output alu_enable_i, alu_operator_i, ex_ready_i,
    output permanent_faulty_alu_i,
    input  alu_sel_o, vote_mode_o, degraded_o,
    input  clock_en_o, fault_event_o, fatal_err_o
  );

  modport slave (
    input  alu_enable_i, alu_operator_i, ex_ready_i,
    input  permanent_faulty_alu_i,
    output alu_sel_o, vote_mode_o, degraded_o,
    output clock_en_o, fault_event_o, fatal_err_o
  );

endinterface

// File: rtl/cv32e40p_alu_sel_ft.sv
// Fault-aware ALU selector for the quad-redundant EX-stage ALU cluster.
// Optional FT_ALU_ROTATE_EN: wear-levelling rotation of the spare ALU.
module cv32e40p_alu_sel_ft
  import cv32e40p_pkg::*;
(
  input logic clk,
  input logic rst_n,
  cv32e40p_alu_sel_ft_if.slave bus
);

  logic [3:0][8:0] snap;
  logic [3:0]      cls;
  logic            cls_vld;
  logic [8:0][3:0] hmap;
  logic [8:0][2:0] cnt;
  logic [8:0]      degraded;
  logic [3:0]      h;
  logic [2:0]      n;
  logic [3:0]      full;
  logic [3:0]      sel;
  logic [1:0]      mode;
  logic [3:0]      ce;
  logic            new_fault;
  logic            fault_event;
  logic            fatal;

  always_comb begin
    cls     = 4'd0;
    cls_vld = 1'b1;
    case (bus.alu_operator_i)
      ALU_ADD, ALU_SUB, ALU_ADDU, ALU_SUBU,
      ALU_ADDR, ALU_SUBR, ALU_ADDUR, ALU_SUBUR,
      ALU_SRA, ALU_SRL, ALU_ROR, ALU_SLL:
        cls = 4'd0;
      ALU_XOR, ALU_OR, ALU_AND:
        cls = 4'd1;
      ALU_BEXT, ALU_BEXTU, ALU_BINS,
      ALU_BCLR, ALU_BSET, ALU_BREV:
        cls = 4'd2;
      ALU_FF1, ALU_FL1, ALU_CNT, ALU_CLB:
        cls = 4'd3;
      ALU_EXTS, ALU_EXT, ALU_SHUF, ALU_SHUF2,
      ALU_PCKLO, ALU_PCKHI, ALU_INS:
        cls = 4'd4;
      ALU_LTS, ALU_LTU, ALU_LES, ALU_LEU,
      ALU_GTS, ALU_GTU, ALU_GES, ALU_GEU,
      ALU_EQ, ALU_NE, ALU_SLTS, ALU_SLTU,
      ALU_SLETS, ALU_SLETU:
        cls = 4'd5;
      ALU_ABS, ALU_CLIP, ALU_CLIPU:
        cls = 4'd6;
      ALU_MIN, ALU_MINU, ALU_MAX, ALU_MAXU:
        cls = 4'd7;
      ALU_DIVU, ALU_DIV, ALU_REMU, ALU_REM:
        cls = 4'd8;
      default:
        cls_vld = 1'b0;
    endcase
  end

  // Healthy-ALU masks and counts for every class.
  always_comb begin
    hmap     = '0;
    cnt      = '0;
    degraded = '0;
    for (int c = 0; c < 9; c++) begin
      for (int i = 0; i < 4; i++) begin
        hmap[c][i] = ~snap[i][c];
        cnt[c]     = cnt[c] + {2'b00, ~snap[i][c]};
      end
      degraded[c] = (cnt[c] < 3'd3);
    end
  end

  always_comb begin
    h = '0;
    n = '0;
    for (int c = 0; c < 9; c++) begin
      if (cls == 4'(c)) begin
        h = hmap[c];
        n = cnt[c];
      end
    end
  end

`ifdef FT_ALU_ROTATE_EN
  logic [1:0] ptr;

  assign full = ~(4'b0001 << ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (bus.alu_enable_i && bus.ex_ready_i &&
                 cls_vld && n == 3'd4) begin
      ptr <= ptr + 2'd1;
    end
  end
`else
  assign full = 4'b0111;
`endif

  // Gated by rst_n so an asserted reset blanks the selection at once.
  always_comb begin
    sel  = '0;
    mode = 2'b00;
    if (bus.alu_enable_i && rst_n) begin
      if (!cls_vld) begin
        sel  = 4'b0111;
        mode = 2'b11;
      end else begin
        case (n)
          3'd4:    begin sel = full; mode = 2'b11; end
          3'd3:    begin sel = h;    mode = 2'b11; end
          3'd2:    begin sel = h;    mode = 2'b10; end
          3'd1:    begin sel = h;    mode = 2'b01; end
          default: begin sel = '0;   mode = 2'b00; end
        endcase
      end
    end
  end

  always_comb begin
    ce = '0;
    for (int i = 0; i < 4; i++) begin
      ce[i] = ~&snap[i];
    end
  end

  assign new_fault = |(bus.permanent_faulty_alu_i & ~snap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap        <= '0;
      fault_event <= 1'b0;
      fatal       <= 1'b0;
    end else begin
      if (bus.ex_ready_i) begin
        snap <= snap | bus.permanent_faulty_alu_i;
      end
      fault_event <= bus.ex_ready_i & new_fault;
      if (bus.alu_enable_i && cls_vld && n == 3'd0) begin
        fatal <= 1'b1;
      end
    end
  end

  assign bus.alu_sel_o     = sel;
  assign bus.vote_mode_o   = mode;
  assign bus.degraded_o    = degraded;
  assign bus.clock_en_o    = ce;
  assign bus.fault_event_o = fault_event;
  assign bus.fatal_err_o   = fatal;

endmodule

// File: tb/tb_cv32e40p_alu_sel_ft.sv
// Self-checking bench for the fault-aware ALU selector.
// Expected selections are queued on drive and compared on output.
module tb_cv32e40p_alu_sel_ft;
  import cv32e40p_pkg::*;

  typedef struct packed {
    logic [3:0] sel;
    logic [1:0] mode;
  } exp_t;

  logic clk;
  logic rst_n;
  int   nasserts;
  int   nfail;
  exp_t sb[$];

  cv32e40p_alu_sel_ft_if bus ();

  cv32e40p_alu_sel_ft dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic en, input logic [6:0] op,
                       input logic rdy);
    bus.alu_enable_i   = en;
    bus.alu_operator_i = op;
    bus.ex_ready_i     = rdy;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b0, 7'(ALU_ADD), 1'b0);
    bus.permanent_faulty_alu_i = '0;
    #3;
    nasserts++;
    if (bus.alu_sel_o !== 4'b0000) begin
      nfail++;
      $display("FAIL reset_sel got %b want 0000", bus.alu_sel_o);
    end
    nasserts++;
    if (bus.vote_mode_o !== 2'b00) begin
      nfail++;
      $display("FAIL reset_mode got %b want 00", bus.vote_mode_o);
    end
    nasserts++;
    if (bus.degraded_o !== 9'h000) begin
      nfail++;
      $display("FAIL reset_degraded got %h want 000", bus.degraded_o);
    end
    nasserts++;
    if (bus.clock_en_o !== 4'b1111) begin
      nfail++;
      $display("FAIL reset_clock_en got %b want 1111", bus.clock_en_o);
    end
    nasserts++;
    if (bus.fault_event_o !== 1'b0 || bus.fatal_err_o !== 1'b0) begin
      nfail++;
      $display("FAIL reset_flags got ev=%b fatal=%b want 0 0",
               bus.fault_event_o, bus.fatal_err_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_rotation;
    logic [3:0] rot [0:5];
    exp_t e;
`ifdef FT_ALU_ROTATE_EN
    rot[0] = 4'b1110; rot[1] = 4'b1101; rot[2] = 4'b1011;
    rot[3] = 4'b0111; rot[4] = 4'b1110; rot[5] = 4'b1101;
`else
    for (int k = 0; k < 6; k++) rot[k] = 4'b0111;
`endif
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1'b1, 7'(ALU_ADD), 1'b1);
      sb.push_back('{sel: rot[k], mode: 2'b11});
      #2;
      e = sb.pop_front();
      nasserts++;
      if (bus.alu_sel_o !== e.sel || bus.vote_mode_o !== e.mode) begin
        nfail++;
        $display("FAIL rotate_add%0d got %b/%b want %b/%b", k,
                 bus.alu_sel_o, bus.vote_mode_o, e.sel, e.mode);
      end
    end
    @(negedge clk);
    drive(1'b1, 7'b1111111, 1'b1);
    sb.push_back('{sel: 4'b0111, mode: 2'b11});
    #2;
    e = sb.pop_front();
    nasserts++;
    if (bus.alu_sel_o !== e.sel || bus.vote_mode_o !== e.mode) begin
      nfail++;
      $display("FAIL unclassified got %b/%b want %b/%b",
               bus.alu_sel_o, bus.vote_mode_o, e.sel, e.mode);
    end
    @(negedge clk);
    drive(1'b1, 7'(ALU_ADD), 1'b1);
    sb.push_back('{sel: rot[5], mode: 2'b11});
    #2;
    e = sb.pop_front();
    nasserts++;
    if (bus.alu_sel_o !== e.sel || bus.vote_mode_o !== e.mode) begin
      nfail++;
      $display("FAIL rotate_after_unclass got %b/%b want %b/%b",
               bus.alu_sel_o, bus.vote_mode_o, e.sel, e.mode);
    end
  endtask

  task automatic test_fault_event;
    exp_t e;
    logic [3:0] add_exp [0:1];
`ifdef FT_ALU_ROTATE_EN
    add_exp[0] = 4'b1011; add_exp[1] = 4'b0111;
`else
    add_exp[0] = 4'b0111; add_exp[1] = 4'b0111;
`endif
    @(negedge clk);
    drive(1'b0, 7'(ALU_ADD), 1'b1);
    bus.permanent_faulty_alu_i[1][1] = 1'b1;
    #2;
    nasserts++;
    if (bus.fault_event_o !== 1'b0) begin
      nfail++;
      $display("FAIL event_early got %b want 0", bus.fault_event_o);
    end
    @(negedge clk);
    nasserts++;
    if (bus.fault_event_o !== 1'b1) begin
      nfail++;
      $display("FAIL event_pulse got %b want 1", bus.fault_event_o);
    end
    drive(1'b1, 7'(ALU_XOR), 1'b1);
    sb.push_back('{sel: 4'b1101, mode: 2'b11});
    #2;
    e = sb.pop_front();
    nasserts++;
    if (bus.alu_sel_o !== e.sel || bus.vote_mode_o !== e.mode) begin
      nfail++;
      $display("FAIL xor_sel got %b/%b want %b/%b",
               bus.alu_sel_o, bus.vote_mode_o, e.sel, e.mode);
    end
    nasserts++;
    if (bus.degraded_o !== 9'h000) begin
      nfail++;
      $display("FAIL xor_degraded got %h want 000", bus.degraded_o);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (k == 0) begin
        nasserts++;
        if (bus.fault_event_o !== 1'b0) begin
          nfail++;
          $display("FAIL event_rereport got %b want 0",
                   bus.fault_event_o);
        end
      end
      drive(1'b1, 7'(ALU_ADD), 1'b1);
      sb.push_back('{sel: add_exp[k], mode: 2'b11});
      #2;
      e = sb.pop_front();
      nasserts++;
      if (bus.alu_sel_o !== e.sel || bus.vote_mode_o !== e.mode) begin
        nfail++;
        $display("FAIL add_after_xor%0d got %b/%b want %b/%b", k,
                 bus.alu_sel_o, bus.vote_mode_o, e.sel, e.mode);
      end
    end
  endtask

  task automatic test_div_stall;
    exp_t e;
    @(negedge clk);
    drive(1'b0, 7'(ALU_ADD), 1'b1);
    bus.permanent_faulty_alu_i[0][8] = 1'b1;
    bus.permanent_faulty_alu_i[2][8] = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      drive(1'b1, 7'(ALU_DIV), (k == 10));
      if (k == 3) bus.permanent_faulty_alu_i[1][8] = 1'b1;
      sb.push_back('{sel: 4'b1010, mode: 2'b10});
      #2;
      e = sb.pop_front();
      nasserts++;
      if (bus.alu_sel_o !== e.sel || bus.vote_mode_o !== e.mode) begin
        nfail++;
        $display("FAIL div_stall%0d got %b/%b want %b/%b", k,
                 bus.alu_sel_o, bus.vote_mode_o, e.sel, e.mode);
      end
      if (k == 0) begin
        nasserts++;
        if (bus.degraded_o !== 9'h100) begin
          nfail++;
          $display("FAIL div_degraded got %h want 100", bus.degraded_o);
        end
      end
    end
    @(negedge clk);
    nasserts++;
    if (bus.fault_event_o !== 1'b1) begin
      nfail++;
      $display("FAIL div_event got %b want 1", bus.fault_event_o);
    end
    drive(1'b1, 7'(ALU_DIV), 1'b0);
    sb.push_back('{sel: 4'b1000, mode: 2'b01});
    #2;
    e = sb.pop_front();
    nasserts++;
    if (bus.alu_sel_o !== e.sel || bus.vote_mode_o !== e.mode) begin
      nfail++;
      $display("FAIL div_single got %b/%b want %b/%b",
               bus.alu_sel_o, bus.vote_mode_o, e.sel, e.mode);
    end
  endtask

  task automatic test_fatal;
    exp_t e;
    @(negedge clk);
    drive(1'b0, 7'(ALU_ADD), 1'b1);
    for (int i = 0; i < 4; i++) bus.permanent_faulty_alu_i[i][5] = 1'b1;
    @(negedge clk);
    drive(1'b1, 7'(ALU_EQ), 1'b1);
    sb.push_back('{sel: 4'b0000, mode: 2'b00});
    #2;
    e = sb.pop_front();
    nasserts++;
    if (bus.alu_sel_o !== e.sel || bus.vote_mode_o !== e.mode) begin
      nfail++;
      $display("FAIL eq_none got %b/%b want %b/%b",
               bus.alu_sel_o, bus.vote_mode_o, e.sel, e.mode);
    end
    nasserts++;
    if (bus.fatal_err_o !== 1'b0) begin
      nfail++;
      $display("FAIL fatal_early got %b want 0", bus.fatal_err_o);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(1'b0, 7'(ALU_EQ), 1'b1);
      #2;
      nasserts++;
      if (bus.fatal_err_o !== 1'b1) begin
        nfail++;
        $display("FAIL fatal_sticky%0d got %b want 1", k,
                 bus.fatal_err_o);
      end
    end
    nasserts++;
    if (bus.degraded_o !== 9'h120) begin
      nfail++;
      $display("FAIL fatal_degraded got %h want 120", bus.degraded_o);
    end
  endtask

  task automatic test_clock_en_reset;
    exp_t e;
    @(negedge clk);
    drive(1'b0, 7'(ALU_ADD), 1'b1);
    bus.permanent_faulty_alu_i[2] = 9'h1ff;
    #2;
    nasserts++;
    if (bus.clock_en_o !== 4'b1111) begin
      nfail++;
      $display("FAIL clock_en_early got %b want 1111", bus.clock_en_o);
    end
    @(negedge clk);
    #2;
    nasserts++;
    if (bus.clock_en_o !== 4'b1011) begin
      nfail++;
      $display("FAIL clock_en got %b want 1011", bus.clock_en_o);
    end
    nasserts++;
    if (bus.degraded_o !== 9'h122) begin
      nfail++;
      $display("FAIL alu2_degraded got %h want 122", bus.degraded_o);
    end
    nasserts++;
    if (bus.fault_event_o !== 1'b1) begin
      nfail++;
      $display("FAIL alu2_event got %b want 1", bus.fault_event_o);
    end
    drive(1'b1, 7'(ALU_ADD), 1'b1);
    sb.push_back('{sel: 4'b1011, mode: 2'b11});
    #1;
    e = sb.pop_front();
    nasserts++;
    if (bus.alu_sel_o !== e.sel || bus.vote_mode_o !== e.mode) begin
      nfail++;
      $display("FAIL add_alu2_dead got %b/%b want %b/%b",
               bus.alu_sel_o, bus.vote_mode_o, e.sel, e.mode);
    end
    rst_n = 1'b0;
    #1;
    nasserts++;
    if (bus.alu_sel_o !== 4'b0000 || bus.vote_mode_o !== 2'b00) begin
      nfail++;
      $display("FAIL midrst_sel got %b/%b want 0000/00",
               bus.alu_sel_o, bus.vote_mode_o);
    end
    nasserts++;
    if (bus.clock_en_o !== 4'b1111 || bus.degraded_o !== 9'h000) begin
      nfail++;
      $display("FAIL midrst_ce_deg got %b/%h want 1111/000",
               bus.clock_en_o, bus.degraded_o);
    end
    nasserts++;
    if (bus.fault_event_o !== 1'b0 || bus.fatal_err_o !== 1'b0) begin
      nfail++;
      $display("FAIL midrst_flags got ev=%b fatal=%b want 0 0",
               bus.fault_event_o, bus.fatal_err_o);
    end
    @(negedge clk);
    drive(1'b0, 7'(ALU_ADD), 1'b0);
    bus.permanent_faulty_alu_i = '0;
    rst_n = 1'b1;
  endtask

  initial begin
    nasserts = 0;
    nfail    = 0;
    test_reset();
    test_rotation();
    test_fault_event();
    test_div_stall();
    test_fatal();
    test_clock_en_reset();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nasserts, nfail);
    $finish;
  end

endmodule

// File: doc/cv32e40p_alu_sel_ft.md
# cv32e40p_alu_sel_ft

Fault-aware ALU selector for the quad-redundant ALU cluster in the fault-tolerant EX stage. It reads the per-ALU, per-sub-unit permanent-fault map produced by the ALU error counters and decodes the current ALU operator into one of 9 sub-unit classes. For each operation it picks which ALUs execute and which vote mode the result voter uses (TMR/DMR/single/none). It also returns clock enables to the error counters and raises sticky fatal and fault-event indications.

## Interface
- No parameters; `ALU_OP_WIDTH` and the `ALU_*` operator encodings come from `cv32e40p_pkg`.
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous, active-low reset
- `alu_enable_i`  in  1  an ALU operation is present in EX this cycle
- `alu_operator_i`  in  ALU_OP_WIDTH  ALU operator of that operation
- `ex_ready_i`  in  1  EX stage advances this cycle (operation accepted)
- `permanent_faulty_alu_i`  in  [3:0][8:0]  fault map from the counters: [alu][class], 1 = faulty
- `alu_sel_o`  out  4  one-hot-per-ALU execute enables
- `vote_mode_o`  out  2  11 TMR, 10 DMR, 01 SINGLE, 00 NONE
- `degraded_o`  out  9  per class: fewer than 3 healthy ALUs in the snapshot
- `clock_en_o`  out  4  error-counter clock enable per ALU
- `fault_event_o`  out  1  one-cycle pulse when a new fault bit is captured
- `fatal_err_o`  out  1  sticky: an operation was issued with no healthy ALU

## Operation
- Class decode, index = fault-map bit:
  - 0 add/sub/shift (ADD…SUBUR, SRA, SRL, ROR, SLL)
  - 1 logic (XOR, OR, AND)
  - 2 bit-manip (BEXT, BEXTU, BINS, BCLR, BSET, BREV)
  - 3 bit-count (FF1, FL1, CNT, CLB)
  - 4 shuffle (EXTS, EXT, SHUF, SHUF2, PCKLO, PCKHI, INS)
  - 5 comparison (LTS…SLETU)
  - 6 abs/clip (ABS, CLIP, CLIPU)
  - 7 min/max (MIN, MINU, MAX, MAXU)
  - 8 div/rem (DIVU, DIV, REMU, REM)
  - Any other operator is unclassified.
- Snapshot register `snap[3:0][8:0]`. On each cycle with `ex_ready_i=1` it updates as `snap <= snap | permanent_faulty_alu_i`. The update is monotonic; only reset clears it.
- For class c, the healthy set is H[i] = ~snap[i][c], and n = popcount(H).
- Selection and vote mode are combinational from `snap`, `ptr` and the class. They are valid only when `alu_enable_i=1`; otherwise both outputs are 0.
  - n=4: `alu_sel_o` = 4'b1111 with bit `ptr` cleared; mode TMR.
  - n=3: `alu_sel_o` = H; mode TMR.
  - n=2: `alu_sel_o` = H; mode DMR.
  - n=1: `alu_sel_o` = H; mode SINGLE.
  - n=0: `alu_sel_o` = 0; mode NONE.
  - Unclassified operator: `alu_sel_o` = 4'b0111, mode TMR, `ptr` ignored.
- Rotation pointer `ptr[1:0]` advances by 1 when `alu_enable_i & ex_ready_i` and the class has n=4. It wraps 3→0.
- `degraded_o[c]` = (n_c < 3), computed combinationally from `snap` for all 9 classes.
- `clock_en_o[i]` = ~&snap[i]. Counting stops once every sub-unit of that ALU is marked faulty.
- `fault_event_o` is registered and equals `ex_ready_i & |(permanent_faulty_alu_i & ~snap)` from the previous cycle.
- `fatal_err_o` sets when `alu_enable_i` is high with n=0 for a classified operator, independent of `ex_ready_i`. Only reset clears it.

## Timing
- Reset (asynchronous) clears `snap`, `ptr`, `fault_event_o` and `fatal_err_o`. After reset, with enable low, the outputs are:
  - `alu_sel_o`=0, `vote_mode_o`=00
  - `degraded_o`=0
  - `clock_en_o`=4'b1111
- Selection latency: 0 cycles from operator to `alu_sel_o`. A newly reported fault affects selection starting the cycle after it is captured.
- A fault captured in the same cycle as an accepted operation does not change that operation's selection.
- While `ex_ready_i=0` (for example a multicycle div), `snap` and `ptr` are frozen, so the selection stays stable for the whole operation.
- `fault_event_o` goes high exactly 1 cycle after capture and stays high for 1 cycle. Re-reporting bits already in `snap` does not pulse.
- A reset asserted mid-operation drops all outputs to their reset values immediately.

## Configuration
- `FT_ALU_ROTATE_EN` defined: wear-levelling rotation via `ptr` as described above.
- Not defined: `ptr` is not implemented. For n=4 the selection is fixed at 4'b0111 (ALU3 is the spare), and all other rules are unchanged.

## Test plan
- Reset, then ALU_ADD with enable and ready on 5 consecutive cycles and no faults → `alu_sel_o` = 1110, 1101, 1011, 0111, 1110; mode 11. Without the macro, all 5 are 0111.
- Set `permanent_faulty_alu_i[1][1]=1` with ready, then issue ALU_XOR → `fault_event_o` pulses once in the next cycle. ALU_XOR selects 1101, mode 11, with no rotation. ALU_ADD continues rotating.
- Fault class 8 on ALUs 0 and 2, then issue ALU_DIV with `ex_ready_i=0` for 10 cycles → `alu_sel_o`=1010 and mode 10 throughout. `degraded_o[8]=1`. Faults reported during the stall do not change the selection.
- Fault class 5 on all 4 ALUs, then issue ALU_EQ → `alu_sel_o`=0, mode 00, and `fatal_err_o` goes high and stays high after enable drops.
- Set all 9 bits of ALU2 → `clock_en_o`=1011 one cycle later. Assert `rst_n` low mid-stream → all outputs return to their reset values asynchronously.
